// File: rtl/fp_pkg.sv
// Shared FP-datapath definitions: shifter mode encodings, mantissa width and
// the split of log-shifter levels across pipeline stages.
package fp_pkg;

  localparam int WIDTH_MANT = 23;

  typedef enum logic [1:0] {
    SH_LSR = 2'b00,
    SH_LSL = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_mode_e;

  function automatic int levels_per_stage(input int shw, input int stages);
    return (shw + stages - 1) / stages;
  endfunction

  function automatic int stage_first_level(input int shw, input int stages, input int k);
    int first;
    first = k * levels_per_stage(shw, stages);
    return (first > shw) ? shw : first;
  endfunction

  // The last stage takes whatever is left; stages past the end get no levels.
  function automatic int stage_num_levels(input int shw, input int stages, input int k);
    int first;
    int last;
    first = stage_first_level(shw, stages, k);
    if (k == stages - 1) return shw - first;
    last = first + levels_per_stage(shw, stages);
    if (last > shw) last = shw;
    return last - first;
  endfunction

endpackage

// File: rtl/bsr_level.sv
// One combinational log-shifter level: shifts by 2**LEVEL when enabled and
// folds the bits it discards into the running lost flag.
module bsr_level
  import fp_pkg::*;
#(
  parameter int WIDTH = WIDTH_MANT,
  parameter int LEVEL = 0
) (
  input  logic             en,
  input  sh_mode_e         mode,
  input  logic [WIDTH-1:0] d,
  input  logic             lost_in,
  output logic [WIDTH-1:0] q,
  output logic             lost_out
);

  localparam int SH  = 1 << LEVEL;
  localparam int ROT = SH % WIDTH;

  function automatic logic [WIDTH-1:0] mask_range(input int lo, input int hi);
    logic [WIDTH-1:0] m;
    for (int b = 0; b < WIDTH; b++) m[b] = (b >= lo) && (b < hi);
    return m;
  endfunction

  // Shifts of SH >= WIDTH naturally saturate: every bit falls inside the mask.
  localparam logic [WIDTH-1:0] LO_MASK = mask_range(0, SH);
  localparam logic [WIDTH-1:0] HI_MASK = mask_range(WIDTH - SH, WIDTH);

  always_comb begin
    // NOTE: defaults first so every path assigns q/lost_out; otherwise a latch is inferred.
    q        = d;
    lost_out = lost_in;
    if (en) begin
      case (mode)
        SH_LSR: begin
          q        = d >> SH;
          lost_out = lost_in | (|(d & LO_MASK));
        end
        SH_LSL: begin
          q        = d << SH;
          lost_out = lost_in | (|(d & HI_MASK));
        end
        SH_ASR: begin
          q        = $signed(d) >>> SH;
          lost_out = lost_in | (|(d & LO_MASK));
        end
        SH_ROR: begin
          q        = (d >> ROT) | (d << (WIDTH - ROT));
          lost_out = lost_in;
        end
      endcase
    end
  end

endmodule

// File: rtl/bsr_pipe.sv
// Pipelined multi-mode barrel shifter (LSR/LSL/ASR/ROR) with lost-bit detect
// and valid/ready flow control; latency equals STAGES.
module bsr_pipe
  import fp_pkg::*;
#(
  parameter int WIDTH  = WIDTH_MANT,
  parameter int SHW    = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   sel,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             lost
);

  localparam int LAST = STAGES - 1;

  logic [WIDTH-1:0]  r_data [STAGES];
  logic [SHW-1:0]    r_sel  [STAGES];
  sh_mode_e          r_mode [STAGES];
  logic              r_lost [STAGES];
  logic [STAGES-1:0] r_valid;

  logic [WIDTH-1:0]  n_data [STAGES];
  logic [SHW-1:0]    n_sel  [STAGES];
  sh_mode_e          n_mode [STAGES];
  logic              n_lost [STAGES];
  logic [STAGES-1:0] n_valid;
  logic [STAGES-1:0] load;

  sh_mode_e         in_mode;
  logic [SHW-1:0]   sel_mod;
  logic [SHW-1:0]   in_sel;

  // Rotation wraps at WIDTH, which need not be a power of two, so reduce first.
  assign in_mode = sh_mode_e'(mode);
  assign sel_mod = SHW'(32'(sel) % WIDTH);
  assign in_sel  = (in_mode == SH_ROR) ? sel_mod : sel;

  // Walk back from the output: a stage loads when empty or when it drains.
  always_comb begin
    logic take;
    take = out_ready;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = !r_valid[k] || take;
      take    = load[k];
    end
  end

  assign in_ready = load[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int FIRST = stage_first_level(SHW, STAGES, k);
    localparam int NLEV  = stage_num_levels(SHW, STAGES, k);

    logic [WIDTH-1:0] d  [NLEV+1];
    logic             lo [NLEV+1];
    logic [SHW-1:0]   s_sel;
    sh_mode_e         s_mode;

    if (k == 0) begin : g_src
      assign d[0]       = in_data;
      assign lo[0]      = 1'b0;
      assign s_sel      = in_sel;
      assign s_mode     = in_mode;
      assign n_valid[0] = in_valid;
    end else begin : g_src
      assign d[0]       = r_data[k-1];
      assign lo[0]      = r_lost[k-1];
      assign s_sel      = r_sel[k-1];
      assign s_mode     = r_mode[k-1];
      assign n_valid[k] = r_valid[k-1];
    end

    for (genvar j = 0; j < NLEV; j++) begin : g_lvl
      bsr_level #(
        .WIDTH (WIDTH),
        .LEVEL (FIRST + j)
      ) u_level (
        .en       (s_sel[FIRST+j]),
        .mode     (s_mode),
        .d        (d[j]),
        .lost_in  (lo[j]),
        .q        (d[j+1]),
        .lost_out (lo[j+1])
      );
    end

    assign n_data[k] = d[NLEV];
    assign n_lost[k] = lo[NLEV];
    assign n_sel[k]  = s_sel;
    assign n_mode[k] = s_mode;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all stages update together.
    if (reset) begin
      r_valid <= '0;
      // NOTE: the datapath registers are reset as well, since out_data/lost must read 0 after reset.
      for (int k = 0; k < STAGES; k++) begin
        r_data[k] <= '0;
        r_sel[k]  <= '0;
        r_mode[k] <= SH_LSR;
        r_lost[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          r_valid[k] <= n_valid[k];
          r_data[k]  <= n_data[k];
          r_sel[k]   <= n_sel[k];
          r_mode[k]  <= n_mode[k];
          r_lost[k]  <= n_lost[k];
        end
      end
    end
  end

  assign out_valid = r_valid[LAST];
  assign out_data  = r_data[LAST];
  assign lost      = r_lost[LAST];

endmodule

// File: tb/tb_bsr_pipe.sv
// Scoreboard bench for bsr_pipe: the driver queues hand-computed results on
// accept, an independent monitor pops and compares on each output transfer.
module tb_bsr_pipe;
  import fp_pkg::*;

  localparam int WIDTH  = 23;
  localparam int SHW    = 5;
  localparam int STAGES = 2;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   sel;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             lost;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             lost;
    bit               chk_lat;
    int               acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  bsr_pipe #(
    .WIDTH  (WIDTH),
    .SHW    (SHW),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .lost      (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one beat until accepted; queue its expected result on the accepting edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic [SHW-1:0] s, input sh_mode_e m,
                      input logic [WIDTH-1:0] ed, input logic el, input bit push, input bit lat);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      sel      = s;
      mode     = m;
      #1;
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        if (push) sb.push_back('{data: ed, lost: el, chk_lat: lat, acc_cyc: cyc});
      end
    end
    if (!acc) begin
      in_valid = 1'b0;
      check("accept_timeout", 64'(in_ready), 64'd1);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin : monitor
    logic [WIDTH-1:0] hold_d;
    logic             hold_l;
    bit               have;
    exp_t             e;
    have = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (out_valid && out_ready) begin
        have = 1'b0;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got data %0h lost %0b, expected no output", out_data, lost);
        end else begin
          e = sb.pop_front();
          check("out_data", 64'(out_data), 64'(e.data));
          check("lost", 64'(lost), 64'(e.lost));
          if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'(STAGES - 1));
        end
      end else if (out_valid && !out_ready && !reset) begin
        if (have) begin
          check("stall_data", 64'(out_data), 64'(hold_d));
          check("stall_lost", 64'(lost), 64'(hold_l));
        end
        hold_d = out_data;
        hold_l = lost;
        have   = 1'b1;
      end else begin
        have = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [WIDTH-1:0] ones;
    ones      = 23'h7FFFFF;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    sel       = '0;
    mode      = 2'b00;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_lost", 64'(lost), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed mode and boundary vectors, free-flowing output.
    send(23'h72F2F2, 5'd4,  SH_LSR, 23'h072F2F, 1'b1, 1'b1, 1'b1);
    send(23'h72F2F2, 5'd4,  SH_LSL, 23'h2F2F20, 1'b1, 1'b1, 1'b1);
    send(23'h72F2F2, 5'd4,  SH_ASR, 23'h7F2F2F, 1'b1, 1'b1, 1'b1);
    send(23'h72F2F2, 5'd4,  SH_ROR, 23'h172F2F, 1'b0, 1'b1, 1'b1);
    send(23'h72F2F2, 5'd30, SH_LSR, 23'h000000, 1'b1, 1'b1, 1'b1);
    send(23'h400000, 5'd23, SH_ASR, 23'h7FFFFF, 1'b1, 1'b1, 1'b1);
    send(23'h000001, 5'd0,  SH_LSR, 23'h000001, 1'b0, 1'b1, 1'b1);
    send(23'h000001, 5'd31, SH_LSL, 23'h000000, 1'b1, 1'b1, 1'b1);
    send(23'h000001, 5'd25, SH_ROR, 23'h200000, 1'b0, 1'b1, 1'b1);
    send(23'h3FFFF8, 5'd3,  SH_ASR, 23'h07FFFF, 1'b0, 1'b1, 1'b1);
    drain();

    // Back-to-back streaming, one beat per cycle.
    for (int k = 0; k < 8; k++)
      send(ones, SHW'(k), SH_LSR, ones >> k, (k != 0), 1'b1, 1'b1);
    drain();

    // Backpressure: two beats fill the pipe, then in_ready must drop.
    @(negedge clk);
    out_ready = 1'b0;
    send(23'h000010, 5'd1,  SH_LSR, 23'h000008, 1'b0, 1'b1, 1'b0);
    send(23'h000003, 5'd2,  SH_LSL, 23'h00000C, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check("bp_in_ready", 64'(in_ready), 64'd0);
    fork
      begin
        send(23'h400001, 5'd1,  SH_ASR, 23'h600000, 1'b1, 1'b1, 1'b0);
        send(23'h000002, 5'd22, SH_ROR, 23'h000004, 1'b0, 1'b1, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight: neither may ever appear.
    @(negedge clk);
    out_ready = 1'b0;
    send(23'h0000FF, 5'd1, SH_LSR, 23'h00007F, 1'b1, 1'b0, 1'b0);
    send(23'h0000F0, 5'd2, SH_LSL, 23'h0003C0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_lost", 64'(lost), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Pipeline still works after the mid-flight reset.
    send(23'h72F2F2, 5'd4, SH_ROR, 23'h172F2F, 1'b0, 1'b1, 1'b1);
    send(23'h000001, 5'd0, SH_ASR, 23'h000001, 1'b0, 1'b1, 1'b1);
    drain();
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
